multibyte_add_ctrl: RTL and testbench
=====================================

MULTIBYTE_ADD_CTRL -- requirements
Module: multibyte_add_ctrl

Interface
REQ-001 Parameter NBYTES, default 4, meaning operand width in bytes; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 in_a  input  8*NBYTES  operand A.
REQ-007 in_b  input  8*NBYTES  operand B.
REQ-008 in_cin  input  1  carry into byte 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 out_sum  output  8*NBYTES  sum bits.
REQ-012 out_cout  output  1  carry out of the top byte.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The block SHALL compute {out_cout, out_sum} = in_a + in_b + in_cin, modulo 2^(8*NBYTES+1), using one shared 8-bit adder instance, one byte per cycle, LSB byte first.
REQ-015 States: IDLE, RUN, DONE.
REQ-016 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-017 On accept: latch in_a, in_b; carry register <= in_cin; byte index <= 0; IDLE -> RUN.
REQ-018 In RUN, each cycle: adder inputs = latched byte[idx] of A and B, Cin = carry register; sum byte written to result[idx]; carry register <= adder Cout; idx <= idx+1.
REQ-019 RUN -> DONE on the cycle idx == NBYTES-1; idx SHALL NOT advance past NBYTES-1 (no wrap into byte 0).
REQ-020 Latency: accept at edge N, out_valid first high after edge N+NBYTES (NBYTES RUN cycles), fixed and data-independent.
REQ-021 In DONE, out_valid = 1; out_sum = result register, out_cout = carry register; both SHALL stay stable until handshake.
REQ-022 DONE -> IDLE when out_ready = 1; out_valid SHALL be 0 in the following cycle; in_ready SHALL be 1 in that same following cycle (no combinational in_ready<-out_ready path).
REQ-023 out_ready held high before DONE SHALL have no effect; in_valid while not in IDLE SHALL be ignored and operands not captured.
REQ-024 Changes on in_a/in_b/in_cin after accept SHALL NOT affect the in-flight result.
REQ-025 out_sum and out_cout SHALL be valid only while out_valid = 1; their value at other times is don't-care but SHALL NOT be X after reset.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, idx = 0, carry = 0, result = 0, in_ready = 1, out_valid = 0, busy = 0, regardless of current state.
REQ-027 Reset during RUN or DONE SHALL abort the operation and discard its result; the next operand set is accepted no earlier than the first edge after rst falls.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/RUN/DONE) and the byte width constant 8.
REQ-029 The datapath SHALL instantiate exactly one existing adder_8bit sub-module; no other arithmetic on operand bits.
REQ-030 idx width SHALL be ceil(log2(NBYTES)), minimum 1.

Verification (NBYTES=4)
REQ-031 A=0xFFFFFFFF, B=0x00000001, cin=0 -> out_sum=0x00000000, out_cout=1, out_valid 4 cycles after accept.
REQ-032 A=0x12345678, B=0x11111111, cin=1 -> out_sum=0x2345678A, out_cout=0.
REQ-033 out_ready held 0 for 10 cycles in DONE, in_valid pulsed with new operands -> result stable, in_ready=0, new operands not captured; out_ready=1 -> IDLE next cycle.
REQ-034 rst asserted on second RUN cycle of A=0x000000FF, B=0x00000001 -> next cycle IDLE, out_valid=0, in_ready=1; following op A=2,B=3 -> out_sum=5.
REQ-035 Back-to-back: out_ready tied 1, in_valid tied 1 with 3 operand sets -> results in order, one accept every NBYTES+2 cycles.
REQ-036 Random 10,000 operand triples vs. reference model {cout,sum}=A+B+cin, plus exhaustive 8-bit sweep with NBYTES=2 upper bytes fixed at 0x00 and 0xFF.

Source files
------------

// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared definitions for the multi-byte serial adder controller.
//   BYTE_W      : width of one datapath slice (one byte per cycle)
//   ST_*        : controller state encoding
//   idx_width() : width of the byte index counter for a given operand size
package multibyte_add_ctrl_pkg;

    localparam int BYTE_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // A 2-byte operand still needs a 1-bit index; $clog2(2) covers that,
    // but guard smaller values so the counter never collapses to zero width.
    function automatic int idx_width(input int nbytes);
        return (nbytes <= 2) ? 1 : $clog2(nbytes);
    endfunction

endpackage

// File: rtl/adder_8bit.sv
// One-byte full adder slice shared across all bytes of the operation.
//   a, b : byte operands
//   cin  : carry in
//   sum  : byte sum
//   cout : carry out
module adder_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'b0, cin};

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Serial multi-byte adder: one byte per cycle through a single 8-bit adder,
// LSB byte first, with valid/ready handshakes on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready only in IDLE)
//   in_a, in_b, in_cin  : operands, captured on accept
//   out_valid/out_ready : result handshake (out_valid only in DONE)
//   out_sum, out_cout   : result bytes and final carry
//   busy                : high whenever not IDLE
//
// state   | meaning
// --------+-------------------------------------------------------
// IDLE    | waiting for operands, in_ready = 1
// RUN     | adding byte idx, carry chained through carry register
// DONE    | result held on out_sum/out_cout until out_ready
module multibyte_add_ctrl
    import multibyte_add_ctrl_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout,
    output logic                     busy
);

    localparam int IDX_W = idx_width(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    logic [1:0]                          state;
    logic [IDX_W-1:0]                    idx;
    logic                                carry;
    logic [NBYTES-1:0][BYTE_W-1:0]       a_q;
    logic [NBYTES-1:0][BYTE_W-1:0]       b_q;
    logic [NBYTES-1:0][BYTE_W-1:0]       result;

    logic [BYTE_W-1:0] sum_byte;
    logic              cout_byte;

    adder_8bit u_adder (
        .a    (a_q[idx]),
        .b    (b_q[idx]),
        .cin  (carry),
        .sum  (sum_byte),
        .cout (cout_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        carry <= in_cin;
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    result[idx] <= sum_byte;
                    carry       <= cout_byte;
                    // Index parks on the last byte so it never wraps to 0.
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // All outputs are decoded from registered state only; no ready-to-ready path.
    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);
    assign out_sum   = result;
    assign out_cout  = carry;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
module tb_multibyte_add_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        in_valid, in_ready, in_cin, out_valid, out_ready, out_cout, busy;
    logic [31:0] in_a, in_b, out_sum;

    logic        v2, r2, c2, ov2, or2, co2, busy2;
    logic [15:0] a2, b2, s2;

    int checks = 0;
    int errors = 0;

    multibyte_add_ctrl #(.NBYTES(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .busy(busy)
    );

    multibyte_add_ctrl #(.NBYTES(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(v2), .in_ready(r2),
        .in_a(a2), .in_b(b2), .in_cin(c2),
        .out_valid(ov2), .out_ready(or2),
        .out_sum(s2), .out_cout(co2), .busy(busy2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transaction on the 4-byte instance; leaves out_ready high
    // so the handshake completes on the following edge.
    task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic early_ready, input string tag);
        logic [32:0] exp;
        int          n;
        exp = {1'b0, a} + {1'b0, b} + 33'(cin);
        @(negedge clk);
        out_ready = early_ready;
        in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        check({tag, " in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_a = $urandom; in_b = $urandom; in_cin = 1'($urandom_range(0, 1));
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check({tag, " latency"}, 64'(n), 64'd4);
        check({tag, " result"}, 64'({out_cout, out_sum}), 64'(exp));
        out_ready = 1'b1;
    endtask

    task automatic op2(input logic [15:0] a, input logic [15:0] b, input logic cin);
        logic [16:0] exp;
        int          n;
        exp = {1'b0, a} + {1'b0, b} + 17'(cin);
        @(negedge clk);
        or2 = 1'b0;
        a2 = a; b2 = b; c2 = cin; v2 = 1'b1;
        n = 0;
        while (!r2 && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        v2 = 1'b0;
        a2 = 16'($urandom); b2 = 16'($urandom);
        n = 0;
        while (!ov2 && n < 20) begin @(negedge clk); n++; end
        check("n2 latency", 64'(n), 64'd2);
        check("n2 result", 64'({co2, s2}), 64'(exp));
        or2 = 1'b1;
    endtask

    logic [31:0] ba [3];
    logic [31:0] bb [3];
    logic        bc [3];

    initial begin
        logic [31:0] held;
        logic        held_c;
        int          n, acc, got, cyc, last_acc;
        logic        pend;
        logic [32:0] e;

        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; a2 = '0; b2 = '0; c2 = 1'b0; or2 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        check("rst out", 64'({out_cout, out_sum}), 64'd0);
        check("rst n2 state", 64'({r2, ov2, busy2}), 64'b100);

        // carry ripples through every byte
        op4(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "ripple");
        @(negedge clk);
        out_ready = 1'b0;
        check("post hs out_valid", 64'(out_valid), 64'd0);
        check("post hs in_ready", 64'(in_ready), 64'd1);
        op4(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, "cin1");

        // hold in DONE, new operands offered must be ignored
        @(negedge clk);
        out_ready = 1'b0;
        in_a = 32'hA5A5_0001; in_b = 32'h0F0F_0002; in_cin = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        e = {1'b0, 32'hA5A5_0001} + {1'b0, 32'h0F0F_0002} + 33'd1;
        n = 0;
        while (!out_valid && n < 20) begin @(negedge clk); n++; end
        check("hold first", 64'({out_cout, out_sum}), 64'(e));
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D; in_cin = 1'b0;
            @(negedge clk);
            check("hold stable", 64'({out_cout, out_sum}), 64'(e));
            check("hold flags", 64'({in_ready, out_valid}), 64'b01);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("hold release", 64'({in_ready, out_valid, busy}), 64'b100);
        @(negedge clk);
        check("hold no capture", 64'(busy), 64'd0);

        // reset in the middle of RUN
        in_a = 32'h0000_00FF; in_b = 32'h0000_0001; in_cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort flags", 64'({in_ready, out_valid, busy}), 64'b100);
        check("abort out", 64'({out_cout, out_sum}), 64'd0);
        op4(32'd2, 32'd3, 1'b0, 1'b0, "after abort");

        // back-to-back with both handshakes held open
        for (int k = 0; k < 3; k++) begin
            ba[k] = $urandom; bb[k] = $urandom; bc[k] = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1;
        in_a = ba[0]; in_b = bb[0]; in_cin = bc[0];
        acc = 0; got = 0; cyc = 0; last_acc = 0; pend = 1'b0;
        while (got < 3 && cyc < 60) begin
            if (pend) begin
                pend = 1'b0;
                if (acc < 3) begin
                    in_a = ba[acc]; in_b = bb[acc]; in_cin = bc[acc];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) begin
                e = {1'b0, ba[got]} + {1'b0, bb[got]} + 33'(bc[got]);
                check("b2b result", 64'({out_cout, out_sum}), 64'(e));
                got++;
            end
            if (in_valid && in_ready) begin
                if (acc > 0) check("b2b spacing", 64'(cyc - last_acc), 64'd6);
                last_acc = cyc;
                acc++;
                pend = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        check("b2b count", 64'(got), 64'd3);
        in_valid = 1'b0;

        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    op4($urandom, $urandom, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), "random");
                end
            end
            begin
                logic [7:0] pat [8];
                for (int a = 0; a < 256; a++) begin
                    pat[0] = 8'h00; pat[1] = 8'h01; pat[2] = 8'h7F; pat[3] = 8'h80;
                    pat[4] = 8'hFE; pat[5] = 8'hFF; pat[6] = 8'(a); pat[7] = ~8'(a);
                    for (int j = 0; j < 8; j++) begin
                        for (int h = 0; h < 2; h++) begin
                            held = (h == 1) ? 32'hFF : 32'h00;
                            held_c = 1'((a + j + h) & 1);
                            op2({held[7:0], 8'(a)}, {held[7:0], pat[j]}, held_c);
                        end
                    end
                end
            end
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
